// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, oversampling ratio and frame data width.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 4;
  localparam int UART_DATA_W     = 8;

  typedef enum logic [1:0] {
    TXD_IDLE  = 2'd0,
    TXD_START = 2'd1,
    TXD_DATA  = 2'd2,
    TXD_STOP  = 2'd3
  } txd_state_t;

endpackage

// File: rtl/uart_transmitter_fifo.sv
// Synchronous circular FIFO holding bytes waiting for the serialiser; 2^DEPTH_N entries.
module uart_transmitter_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_N = 2
) (
  input  logic                   b_bd_clock,
  input  logic                   inRESET,
  input  logic                   wr_req,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_pop,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 1 << DEPTH_N;
  localparam logic [DEPTH_N-1:0] PTR_ONE  = DEPTH_N'(1);
  localparam logic [DEPTH_N:0]   CNT_ONE  = (DEPTH_N+1)'(1);
  localparam logic [DEPTH_N:0]   CNT_FULL = (DEPTH_N+1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_N-1:0]     wr_ptr;
  logic [DEPTH_N-1:0]     rd_ptr;
  logic [DEPTH_N:0]       count;
  logic                   wr_en;
  logic                   rd_en;

  // Full is taken from the registered count, so a write that meets a full
  // FIFO is dropped even if a pop frees a slot on the same edge.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign wr_en   = wr_req && !full;
  assign rd_en   = rd_pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge b_bd_clock or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !rd_en)      count <= count + CNT_ONE;
      else if (rd_en && !wr_en) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge b_bd_clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter in the x4 baud domain: FIFO feeding an 8N1/8N2 serialiser with a registered TXD.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH_N = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic       b_bd_clock,
  input  logic       inRESET,
  input  logic       iTX_REQ,
  input  logic [7:0] iTX_DATA,
  output logic       oTX_FULL,
  output logic       oTX_EMPTY,
  output logic       oTX_BUSY,
  output logic       oUART_TXD
);

  localparam logic [1:0] SUB_LAST  = 2'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_W - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  txd_state_t             state, state_d;
  logic [1:0]             sub_cnt, sub_d;
  logic [2:0]             bit_cnt, bit_d;
  logic                   stop_cnt, stop_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   txd_q, txd_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] fifo_data;
  logic                   fifo_full;
  logic                   fifo_empty;

  uart_transmitter_fifo #(
    .DEPTH_N (FIFO_DEPTH_N)
  ) u_fifo (
    .b_bd_clock (b_bd_clock),
    .inRESET    (inRESET),
    .wr_req     (iTX_REQ),
    .wr_data    (iTX_DATA),
    .rd_pop     (pop),
    .rd_data    (fifo_data),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign oTX_FULL  = fifo_full;
  assign oTX_BUSY  = (state != TXD_IDLE);
  assign oTX_EMPTY = fifo_empty && (state == TXD_IDLE);
  assign oUART_TXD = txd_q;

  always_ff @(posedge b_bd_clock or negedge inRESET) begin
    if (!inRESET) begin
      state    <= TXD_IDLE;
      sub_cnt  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_d;
      sub_cnt  <= sub_d;
      bit_cnt  <= bit_d;
      stop_cnt <= stop_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  // txd_d is the line level for the cycle after this edge, so it is chosen
  // alongside state_d and the line changes exactly when the state does.
  always_comb begin
    state_d = state;
    sub_d   = sub_cnt;
    bit_d   = bit_cnt;
    stop_d  = stop_cnt;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state)
      TXD_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          sub_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          state_d = TXD_START;
          txd_d   = 1'b0;
        end
      end
      TXD_START: begin
        sub_d = sub_cnt + 2'd1;
        if (sub_cnt == SUB_LAST) begin
          state_d = TXD_DATA;
          txd_d   = shift_q[0];
        end
      end
      TXD_DATA: begin
        sub_d = sub_cnt + 2'd1;
        if (sub_cnt == SUB_LAST) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_cnt + 3'd1;
          if (bit_cnt == BIT_LAST) begin
            state_d = TXD_STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d = shift_q[1];
          end
        end
      end
      TXD_STOP: begin
        sub_d = sub_cnt + 2'd1;
        if (sub_cnt == SUB_LAST) begin
          if (stop_cnt == STOP_LAST) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_data;
              sub_d   = '0;
              bit_d   = '0;
              stop_d  = 1'b0;
              state_d = TXD_START;
              txd_d   = 1'b0;
            end else begin
              state_d = TXD_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = TXD_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame timing, FIFO full/drop, 2 stop bits, reset abort, loopback.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req1, req2;
  logic [7:0] data1, data2;
  logic       full1, empty1, busy1, txd1;
  logic       full2, empty2, busy2, txd2;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_transmitter #(.FIFO_DEPTH_N(2), .STOP_BITS(1)) dut (
    .b_bd_clock (clk),
    .inRESET    (rst_n),
    .iTX_REQ    (req1),
    .iTX_DATA   (data1),
    .oTX_FULL   (full1),
    .oTX_EMPTY  (empty1),
    .oTX_BUSY   (busy1),
    .oUART_TXD  (txd1)
  );

  uart_transmitter #(.FIFO_DEPTH_N(2), .STOP_BITS(2)) dut2 (
    .b_bd_clock (clk),
    .inRESET    (rst_n),
    .iTX_REQ    (req2),
    .iTX_DATA   (data2),
    .oTX_FULL   (full2),
    .oTX_EMPTY  (empty2),
    .oTX_BUSY   (busy2),
    .oUART_TXD  (txd2)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // x4 receiver model on dut's line: finds the start bit, samples cell centres.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int t;
    t  = 0;
    ok = 1'b1;
    b  = 8'h00;
    @(negedge clk);
    while (txd1 !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      ok = 1'b0;
      return;
    end
    repeat (2) @(negedge clk);
    if (txd1 !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = txd1;
    end
    repeat (4) @(negedge clk);
    if (txd1 !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req1 = 1'b0; data1 = 8'h00;
    req2 = 1'b0; data2 = 8'h00;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({txd1, full1, empty1, busy1} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_dut1: got txd/full/empty/busy=%b need 1010", {txd1, full1, empty1, busy1});
    end
    tests_run++;
    if ({txd2, full2, empty2, busy2} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_dut2: got txd/full/empty/busy=%b need 1010", {txd2, full2, empty2, busy2});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({txd1, full1, empty1, busy1} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL after_release: got txd/full/empty/busy=%b need 1010", {txd1, full1, empty1, busy1});
    end
  endtask

  task automatic test_single_a5();
    logic [7:0] v;
    logic       e;
    v = 8'hA5;
    @(negedge clk); req1 = 1'b1; data1 = v;
    @(negedge clk); req1 = 1'b0;
    tests_run++;
    if ({txd1, busy1, empty1} !== 3'b100) begin
      tests_failed++;
      $display("FAIL a5_stored: got txd/busy/empty=%b need 100", {txd1, busy1, empty1});
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      e = (k < 4) ? 1'b0 : (k < 36) ? v[(k - 4) / 4] : 1'b1;
      tests_run++;
      if ({txd1, busy1} !== {e, 1'b1}) begin
        tests_failed++;
        $display("FAIL a5_cell k=%0d: got txd/busy=%b need %b", k, {txd1, busy1}, {e, 1'b1});
      end
    end
    @(negedge clk);
    tests_run++;
    if ({txd1, busy1, empty1} !== 3'b101) begin
      tests_failed++;
      $display("FAIL a5_end: got txd/busy/empty=%b need 101", {txd1, busy1, empty1});
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    @(negedge clk); req1 = 1'b1; data1 = 8'h00;
    @(negedge clk); data1 = 8'hFF;
    @(negedge clk); req1 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      e = (k < 36) ? 1'b0 : (k < 40) ? 1'b1 : (k < 44) ? 1'b0 : 1'b1;
      tests_run++;
      if ({txd1, busy1} !== {e, 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_cell k=%0d: got txd/busy=%b need %b", k, {txd1, busy1}, {e, 1'b1});
      end
      @(negedge clk);
    end
    tests_run++;
    if ({txd1, busy1, empty1} !== 3'b101) begin
      tests_failed++;
      $display("FAIL b2b_end: got txd/busy/empty=%b need 101", {txd1, busy1, empty1});
    end
  endtask

  task automatic test_stop2();
    logic [7:0] v;
    logic       e;
    v = 8'h3C;
    @(negedge clk); req2 = 1'b1; data2 = v;
    @(negedge clk); req2 = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      e = (k < 4) ? 1'b0 : (k < 36) ? v[(k - 4) / 4] : 1'b1;
      tests_run++;
      if ({txd2, busy2} !== {e, 1'b1}) begin
        tests_failed++;
        $display("FAIL stop2_cell k=%0d: got txd/busy=%b need %b", k, {txd2, busy2}, {e, 1'b1});
      end
    end
    @(negedge clk);
    tests_run++;
    if ({txd2, busy2, empty2} !== 3'b101) begin
      tests_failed++;
      $display("FAIL stop2_end: got txd/busy/empty=%b need 101", {txd2, busy2, empty2});
    end
  endtask

  // Byte 1 is popped on the edge after it is stored, so writes 2..5 fill the
  // four slots; full is seen after the 5th write and the 6th is dropped.
  task automatic test_fifo_full();
    logic [7:0] b;
    logic       ok;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            tests_run++;
            if (full1 !== ((i - 1) >= 5)) begin
              tests_failed++;
              $display("FAIL full_after_write%0d: got %b need %b", i - 1, full1, ((i - 1) >= 5));
            end
          end
          req1 = 1'b1;
          data1 = 8'(i);
        end
        @(negedge clk);
        req1 = 1'b0;
        tests_run++;
        if (full1 !== 1'b1) begin
          tests_failed++;
          $display("FAIL full_after_write6: got %b need 1", full1);
        end
      end
      begin
        for (int j = 1; j <= 5; j++) begin
          rx_byte(b, ok);
          tests_run++;
          if ({ok, b} !== {1'b1, 8'(j)}) begin
            tests_failed++;
            $display("FAIL full_rx%0d: got ok=%b byte=%h need ok=1 byte=%h", j, ok, b, 8'(j));
          end
        end
      end
    join
    rx_byte(b, ok);
    tests_run++;
    if (ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL dropped_byte: got an extra frame byte=%h need none", b);
    end
    tests_run++;
    if ({empty1, busy1, full1} !== 3'b100) begin
      tests_failed++;
      $display("FAIL full_drain: got empty/busy/full=%b need 100", {empty1, busy1, full1});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic       ok;
    logic       saw_low;
    @(negedge clk); req1 = 1'b1; data1 = 8'h00;
    @(negedge clk); data1 = 8'h11;
    @(negedge clk); req1 = 1'b0;
    repeat (17) @(negedge clk);
    tests_run++;
    if (txd1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_reset_line: got %b need 0", txd1);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({txd1, full1, empty1, busy1} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL async_abort: got txd/full/empty/busy=%b need 1010", {txd1, full1, empty1, busy1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_low = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || empty1 !== 1'b1) saw_low = 1'b1;
    end
    tests_run++;
    if (saw_low !== 1'b0) begin
      tests_failed++;
      $display("FAIL fifo_discard: got activity after reset, need idle line");
    end
    fork
      begin
        @(negedge clk); req1 = 1'b1; data1 = 8'h5A;
        @(negedge clk); req1 = 1'b0;
      end
      rx_byte(b, ok);
    join
    tests_run++;
    if ({ok, b} !== {1'b1, 8'h5A}) begin
      tests_failed++;
      $display("FAIL post_reset_5a: got ok=%b byte=%h need ok=1 byte=5a", ok, b);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    logic       ok;
    exp_q.delete();
    fork
      begin
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        while (n < 256 && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          if (!full1) begin
            req1  = 1'b1;
            data1 = 8'($urandom_range(0, 255));
            exp_q.push_back(data1);
            n++;
          end else begin
            req1 = 1'b0;
          end
        end
        @(negedge clk);
        req1 = 1'b0;
      end
      begin
        for (int j = 0; j < 256; j++) begin
          rx_byte(b, ok);
          tests_run++;
          if (!ok || exp_q.size() == 0 || b !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL loopback%0d: got ok=%b byte=%h need %h", j, ok, b,
                     (exp_q.size() != 0) ? exp_q[0] : 8'h00);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_stop2();
    test_fifo_full();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
